// File: rtl/bk_dec_pkg.sv
// Shared constants, sizing helpers and FSM state type for the Brent-Kung sum decoder.
package bk_dec_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DIGIT = 4;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-digit configuration still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NDIG  = ndig(DEF_WIDTH, DEF_DIGIT);
  localparam int DEF_CNT_W = cnt_width(DEF_NDIG);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/bk_sub_digit.sv
// Combinational DIGIT-bit subtractor slice: {bout, d} = x - y - bin.
module bk_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] diff;

  // The extra top bit of the widened difference is the borrow out.
  assign diff = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d    = diff[DIGIT-1:0];
  assign bout = diff[DIGIT];

endmodule

// File: rtl/bk_sum_decoder.sv
// Serial operand recovery b = sum - a, DIGIT bits per cycle, valid/ready on both sides.
// Optional range-check output out_err is enabled by defining BKDEC_RANGE_CHECK_EN.
module bk_sum_decoder
  import bk_dec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b
`ifdef BKDEC_RANGE_CHECK_EN
  ,
  output logic             out_err
`endif
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = cnt_width(NDIG);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("bk_sum_decoder: WIDTH must be a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT-1:0]   dig_d;
  logic               dig_bout;
  logic [WIDTH+DIGIT-1:0] b_shift;

`ifdef BKDEC_RANGE_CHECK_EN
  logic carry_q, carry_d;
  logic err_q, err_d;
`else
  logic unused_carry;
  assign unused_carry = in_sum[WIDTH];
`endif

  bk_sub_digit #(
    .DIGIT(DIGIT)
  ) u_sub (
    .x   (sum_q[DIGIT-1:0]),
    .y   (a_q[DIGIT-1:0]),
    .bin (borrow_q),
    .d   (dig_d),
    .bout(dig_bout)
  );

  // Operands shift down one digit per cycle; result digits enter from the top.
  assign b_shift = {dig_d, b_q};

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef BKDEC_RANGE_CHECK_EN
    carry_d  = carry_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d    = in_sum[WIDTH-1:0];
          a_d      = in_a;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef BKDEC_RANGE_CHECK_EN
          carry_d  = in_sum[WIDTH];
`endif
          state_d  = CALC;
        end
      end
      CALC: begin
        b_d      = b_shift[WIDTH+DIGIT-1:DIGIT];
        sum_d    = sum_q >> DIGIT;
        a_d      = a_q >> DIGIT;
        borrow_d = dig_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
`ifdef BKDEC_RANGE_CHECK_EN
          // A legal adder output has its carry-out equal to the final borrow.
          err_d   = carry_q ^ dig_bout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef BKDEC_RANGE_CHECK_EN
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef BKDEC_RANGE_CHECK_EN
      carry_q  <= carry_d;
      err_q    <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_b     = b_q;
`ifdef BKDEC_RANGE_CHECK_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_bk_sum_decoder.sv
// Scoreboard bench for bk_sum_decoder: expected (b, err) pushed on accept, popped on output.
module tb_bk_sum_decoder;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] b;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   in_sum = '0;
  logic [W-1:0] in_a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_b;
`ifdef BKDEC_RANGE_CHECK_EN
  logic         out_err;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bk_sum_decoder #(.WIDTH(W), .DIGIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_b    (out_b)
`ifdef BKDEC_RANGE_CHECK_EN
    ,
    .out_err  (out_err)
`endif
  );

  function automatic exp_t model(input logic [W:0] s, input logic [W-1:0] a);
    exp_t e;
    e.b   = s[W-1:0] - a;
    e.err = s[W] ^ (s[W-1:0] < a);
    return e;
  endfunction

  // Drive a request until accepted (bounded); push the expected result on accept.
  task automatic issue(input logic [W:0] s, input logic [W-1:0] a, output bit ok);
    bit acc;
    ok = 1'b0;
    in_valid = 1'b1;
    in_sum = s;
    in_a = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(model(s, a));
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++;
    if (out_b !== '0) begin n_err++; $display("FAIL reset_out_b got=%h exp=000", out_b); end
`ifdef BKDEC_RANGE_CHECK_EN
    n_vec++;
    if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn reset released");
  endtask

  // Applies one request with out_ready optionally pre-asserted, checks latency and result.
  task automatic run_one(input string name, input logic [W:0] s, input logic [W-1:0] a,
                         input bit check_lat);
    bit   ok;
    int   cyc;
    exp_t e;
    issue(s, a, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL %s_accept got=timeout exp=accept", name); return; end
    wait_out(cyc);
    if (check_lat) begin
      n_vec++;
      if (cyc !== 3) begin n_err++; $display("FAIL %s_latency got=%0d exp=3", name, cyc); end
    end
    n_vec++;
    if (!out_valid) begin n_err++; $display("FAIL %s_out_valid got=timeout exp=1", name); return; end
    e = sb.pop_front();
    n_vec++;
    if (out_b !== e.b) begin n_err++; $display("FAIL %s_out_b got=%h exp=%h", name, out_b, e.b); end
`ifdef BKDEC_RANGE_CHECK_EN
    n_vec++;
    if (out_err !== e.err) begin n_err++; $display("FAIL %s_out_err got=%b exp=%b", name, out_err, e.err); end
`endif
    $display("txn %s sum=%h a=%h b=%h exp_b=%h", name, s, a, out_b, e.b);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_return_idle got=valid%b/ready%b exp=valid0/ready1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;  // held high before out_valid: must not disturb anything
    run_one("basic", 13'h0579, 12'h123, 1'b1);
    n_vec++;
    if (model(13'h0579, 12'h123).b !== 12'h456) begin
      n_err++; $display("FAIL basic_model got=%h exp=456", model(13'h0579, 12'h123).b);
    end
  endtask

  task automatic test_max_operands;
    run_one("max_a", 13'h1FFE, 12'hFFF, 1'b1);
    run_one("max_b", 13'h1000, 12'h001, 1'b0);
  endtask

  task automatic test_illegal_pair;
    run_one("illegal", 13'h0005, 12'h006, 1'b1);
  endtask

  task automatic test_backpressure;
    bit   ok;
    int   cyc;
    exp_t e;
    out_ready = 1'b0;
    issue(13'h0ABC, 12'h0BC, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_accept got=timeout exp=accept"); return; end
    wait_out(cyc);
    e = sb.pop_front();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sum = 13'($urandom);
      in_a = 12'($urandom);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_b !== e.b) begin
        n_err++;
        $display("FAIL bp_hold_%0d got=valid%b/ready%b/b=%h exp=valid1/ready0/b=%h",
                 i, out_valid, in_ready, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release got=ready%b/valid%b exp=ready1/valid0", in_ready, out_valid);
    end
    $display("txn backpressure b=%h exp_b=%h", out_b, e.b);
  endtask

  task automatic test_reset_mid;
    bit ok;
    issue(13'h0579, 12'h123, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstmid_accept got=timeout exp=accept"); return; end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_b !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_abort got=valid%b/b=%h/ready%b exp=valid0/b=000/ready1",
               out_valid, out_b, in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn reset mid-calc aborted");
    run_one("after_rst", 13'h0579, 12'h123, 1'b1);
  endtask

  task automatic test_back_to_back;
    int           sent = 0;
    int           rcvd = 0;
    bit           fire_in, fire_out;
    logic [W-1:0] a, b;
    exp_t         e;
    a = 12'($urandom);
    b = 12'($urandom);
    in_sum = {1'b0, a} + {1'b0, b};
    in_a = a;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 5000 && rcvd < 100; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_dup got=b=%h exp=no_output", out_b);
        end else begin
          e = sb.pop_front();
          if (out_b !== e.b) begin
            n_err++; $display("FAIL b2b_out_b[%0d] got=%h exp=%h", rcvd, out_b, e.b);
          end
          $display("txn b2b %0d b=%h exp_b=%h", rcvd, out_b, e.b);
        end
        rcvd++;
      end
      @(posedge clk);
      #1;
      if (fire_in) begin
        sb.push_back(model(in_sum, in_a));
        sent++;
        if (sent < 100) begin
          a = 12'($urandom);
          b = 12'($urandom);
          in_sum = {1'b0, a} + {1'b0, b};
          in_a = a;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (rcvd !== 100 || sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count got=rcvd%0d/pending%0d exp=rcvd100/pending0", rcvd, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    out_ready = 1'b0;
    test_max_operands();
    test_illegal_pair();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bk_sum_decoder.md
Name: bk_sum_decoder

Overview:
- Inverse of the team's 12-bit Brent-Kung adder.
- Takes a (WIDTH+1)-bit sum word and one operand `a`, and recovers the other operand: b = sum - a.
- Computes serially, DIGIT bits per cycle, with valid/ready handshakes on both sides.
- Sits downstream of adder outputs in self-check and operand-recovery paths.

Parameters:
- WIDTH, 12, operand width in bits; the sum is WIDTH+1 bits.
- DIGIT, 4, bits subtracted per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_sum  in  WIDTH+1  sum word; bit WIDTH is the carry-out.
- in_a  in  WIDTH  known operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_b  out  WIDTH  recovered operand.
- out_err  out  1  present only with BKDEC_RANGE_CHECK_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_b=0, out_err=0, internal borrow=0, digit counter=0.
- NDIG = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_sum and in_a, clear borrow, counter=0, go to CALC.
  - in_sum and in_a are ignored in every other cycle.
- CALC:
  - in_ready=0.
  - Each cycle k (0..NDIG-1): digit k of out_b = sum[k] - a[k] - borrow, modulo 2^DIGIT; borrow <= 1 if that difference < 0.
  - After digit NDIG-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_b and out_err are held stable while out_ready=0.
  - On out_ready, go to IDLE with out_valid=0. No same-cycle re-accept.
- Latency: out_valid rises exactly NDIG cycles after the accept edge (3 for the defaults). Minimum period per transaction is NDIG+2 cycles.
- Arithmetic:
  - Low WIDTH bits wrap modulo 2^WIDTH.
  - Final borrow bw is kept.
  - The true result is in range iff sum[WIDTH]==bw.
- Boundaries:
  - a=0: out_b = sum[WIDTH-1:0].
  - sum = 2^(WIDTH+1)-2, a = 2^WIDTH-1: out_b = 2^WIDTH-1, no error.
  - out_ready held high before out_valid has no effect.
  - Reset asserted mid-CALC or in DONE aborts the transaction; the partial result is discarded.
- out_b may show partial digits during CALC. It is only valid when out_valid=1.

Optional Feature:
- Macro: BKDEC_RANGE_CHECK_EN.
- Defined:
  - out_err port exists.
  - out_err = sum[WIDTH] ^ bw, registered on entry to DONE and valid with out_valid.
  - It flags a result that does not fit in WIDTH bits, meaning the pair is not a legal adder output.
- Undefined:
  - The port and its logic are absent.
  - Result wraps silently.

Decomposition:
- Package bk_dec_pkg:
  - default WIDTH and DIGIT constants.
  - NDIG localparam function.
  - state enum {IDLE, CALC, DONE}.
  - counter width constant $clog2(NDIG).
- One sub-module, bk_sub_digit: combinational DIGIT-bit subtractor slice (x, y, bin -> d, bout), instantiated once in the datapath.
- FSM, shift/select and registers live in the top level.

Test Plan:
- Basic recovery:
  - Stimulus: in_sum=0x0579, in_a=0x123, out_ready=1.
  - Response: out_valid 3 cycles after accept; out_b=0x456; out_err=0.
- Max operands:
  - Stimulus: in_sum=0x1FFE, in_a=0xFFF.
  - Response: out_b=0xFFF, out_err=0. Then in_sum=0x1000, in_a=0x001 -> out_b=0xFFF, out_err=0.
- Illegal pair (macro on):
  - Stimulus: in_sum=0x0005, in_a=0x006.
  - Response: out_b=0xFFF, out_err=1. With macro off, out_b=0xFFF and no port exists.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 and changing in_sum.
  - Response: out_b and out_valid held, in_ready=0, new inputs ignored; IDLE one cycle after out_ready=1.
- Reset mid-operation:
  - Stimulus: rst_n low in CALC cycle 1.
  - Response: immediately out_valid=0, out_b=0, in_ready=1. After release, a fresh request (0x0579, 0x123) returns 0x456.
- Back-to-back:
  - Stimulus: 100 random legal (a, b) pairs with in_valid held high and random out_ready.
  - Response: every out_b matches b in order; no drops or duplicates.
